// File: rtl/div_unit_pkg.sv
// Shared constants and FSM encoding for the multicycle signed divider.
// WIDTH is the datapath width also used by the ALU.
package div_unit_pkg;

    localparam int WIDTH     = 32;
    localparam int CNT_W     = 6;
    localparam int ITER_LAST = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/div_unit_twos_negate.sv
// Two's-complement negation: bitwise inversion followed by +1.
// Used for operand magnitudes and for the quotient/remainder sign fix.
module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [WIDTH-1:0] negated_o
);

    assign negated_o = ~value_i + WIDTH'(1);

endmodule

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: fixed 33-cycle latency from the start edge,
// quotient and remainder registered on a one-cycle ready pulse.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = div_unit_pkg::WIDTH,
    parameter int CNT_W = div_unit_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   partRem_q;
    logic               qNeg_q;
    logic               rNeg_q;
    logic               divZero_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               exception_q;
    logic               resultRdy_q;
    logic               busy_q;

    logic [WIDTH-1:0]   negA;
    logic [WIDTH-1:0]   negB;
    logic [WIDTH-1:0]   negQuot;
    logic [WIDTH-1:0]   negRem;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     remShift;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   partRem_d;
    logic [WIDTH-1:0]   quot_d;

    twos_negate #(.WIDTH(WIDTH)) uNegA   (.value_i(data_operandA), .negated_o(negA));
    twos_negate #(.WIDTH(WIDTH)) uNegB   (.value_i(data_operandB), .negated_o(negB));
    twos_negate #(.WIDTH(WIDTH)) uNegQuot(.value_i(quot_q),        .negated_o(negQuot));
    twos_negate #(.WIDTH(WIDTH)) uNegRem (.value_i(partRem_q),     .negated_o(negRem));

    // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
    assign absA = data_operandA[WIDTH-1] ? negA : data_operandA;
    assign absB = data_operandB[WIDTH-1] ? negB : data_operandB;

    // One restoring step; the extra top bit of the trial result is the borrow.
    always_comb begin
        remShift  = {partRem_q, quot_q[WIDTH-1]};
        trial     = remShift - {1'b0, divisor_q};
        partRem_d = remShift[WIDTH-1:0];
        quot_d    = {quot_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            partRem_d = trial[WIDTH-1:0];
            quot_d    = {quot_q[WIDTH-2:0], 1'b1};
        end
    end

    // A start pulse always wins, so a running op is simply abandoned without a ready pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            divisor_q   <= '0;
            quot_q      <= '0;
            partRem_q   <= '0;
            qNeg_q      <= 1'b0;
            rNeg_q      <= 1'b0;
            divZero_q   <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
            resultRdy_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            resultRdy_q <= 1'b0;
            exception_q <= 1'b0;
            if (ctrl_DIV) begin
                state_q   <= BUSY;
                busy_q    <= 1'b1;
                count_q   <= '0;
                divisor_q <= absB;
                quot_q    <= absA;
                partRem_q <= '0;
                qNeg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                rNeg_q    <= data_operandA[WIDTH-1];
                divZero_q <= (data_operandB == '0);
            end else begin
                case (state_q)
                    IDLE: ;
                    BUSY: begin
                        partRem_q <= partRem_d;
                        quot_q    <= quot_d;
                        count_q   <= count_q + CNT_W'(1);
                        if (count_q == CNT_W'(ITER_LAST)) state_q <= FIN;
                    end
                    FIN: begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        resultRdy_q <= 1'b1;
                        exception_q <= divZero_q;
                        result_q    <= divZero_q ? '0 : (qNeg_q ? negQuot : quot_q);
                        remainder_q <= divZero_q ? '0 : (rNeg_q ? negRem : partRem_q);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exception_q;
    assign data_resultRDY = resultRdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors with literal expectations plus
// an arithmetic reference model compared against the outputs on every cycle.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    bit          active = 0;
    int          startCyc = 0;
    logic [31:0] pendRes = '0;
    logic [31:0] pendRem = '0;
    logic        pendExc = 1'b0;
    logic [31:0] heldRes = '0;
    logic [31:0] heldRem = '0;
    logic        rdyNow = 1'b0;
    logic        excNow = 1'b0;

    div_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Truncating signed division; remainder takes the dividend's sign.
    function automatic void divModel(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r,
                                     output logic e);
        int sa;
        int sb;
        sa = a;
        sb = b;
        e  = 1'b0;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    // Timing model: a start sampled at edge S yields a ready pulse after edge S+33.
    always @(posedge clock) begin
        cyc++;
        if (!reset) begin
            rdyNow = 1'b0;
            excNow = 1'b0;
            if (ctrl_DIV) begin
                active   = 1;
                startCyc = cyc;
                divModel(data_operandA, data_operandB, pendRes, pendRem, pendExc);
            end else if (active && cyc == startCyc + 33) begin
                active  = 0;
                rdyNow  = 1'b1;
                excNow  = pendExc;
                heldRes = pendRes;
                heldRem = pendRem;
            end
        end
    end

    always @(posedge reset) begin
        active  = 0;
        rdyNow  = 1'b0;
        excNow  = 1'b0;
        heldRes = '0;
        heldRem = '0;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("rdy",       {31'd0, data_resultRDY}, {31'd0, rdyNow});
            checkOutput("exception", {31'd0, data_exception}, {31'd0, excNow});
            checkOutput("result",    data_result,    heldRes);
            checkOutput("remainder", data_remainder, heldRem);
            if (!active)
                checkOutput("busyIdle", {31'd0, busy}, 32'd0);
            else if (cyc > startCyc && cyc <= startCyc + 32)
                checkOutput("busyRun", {31'd0, busy}, 32'd1);
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
    endtask

    task automatic waitReady(input string name, output bit seen);
        seen = 0;
        for (int i = 0; i < 45 && !seen; i++) begin
            @(negedge clock);
            if (data_resultRDY) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got no ready pulse expected one within 45 cycles", name);
        end
    endtask

    task automatic expectResult(input string name, input logic [31:0] q,
                                input logic [31:0] r, input logic e);
        bit seen;
        waitReady(name, seen);
        if (seen) begin
            checkOutput({name, ".q"}, data_result, q);
            checkOutput({name, ".r"}, data_remainder, r);
            checkOutput({name, ".e"}, {31'd0, data_exception}, {31'd0, e});
        end
    endtask

    task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic e);
        int t0;
        applyStimulus(a, b);
        t0 = cyc;
        expectResult(name, q, r, e);
        checkOutput({name, ".latency"}, cyc - t0, 32'd33);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        checkOutput("resetResult", data_result, 32'd0);
        checkOutput("resetRemainder", data_remainder, 32'd0);
        checkOutput("resetFlags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
        reset = 1'b0;

        runOp("pos100div7",   32'd100,         32'd7,           32'd14,          32'd2,           1'b0);
        runOp("neg100div7",   32'hFFFF_FF9C,   32'd7,           32'hFFFF_FFF2,   32'hFFFF_FFFE,   1'b0);
        runOp("pos100divNeg7", 32'd100,        32'hFFFF_FFF9,   32'hFFFF_FFF2,   32'd2,           1'b0);
        runOp("divByZero",    32'd5,           32'd0,           32'd0,           32'd0,           1'b1);
        runOp("minDivNeg1",   32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   32'd0,           1'b0);
        runOp("minDiv1",      32'h8000_0000,   32'd1,           32'h8000_0000,   32'd0,           1'b0);

        // Restart mid-operation: only the second op may report.
        applyStimulus(32'd100, 32'd7);
        repeat (8) @(negedge clock);
        runOp("abortRestart", 32'd50, 32'hFFFF_FFFB, 32'hFFFF_FFF6, 32'd0, 1'b0);

        // New start issued during the ready cycle of the previous op.
        applyStimulus(32'd20, 32'd3);
        expectResult("b2bFirst", 32'd6, 32'd2, 1'b0);
        data_operandA = 32'd21;
        data_operandB = 32'd4;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        expectResult("b2bSecond", 32'd5, 32'd1, 1'b0);

        // Asynchronous reset in the middle of a running op.
        applyStimulus(32'd100, 32'd7);
        repeat (14) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("midResetResult", data_result, 32'd0);
        checkOutput("midResetRemainder", data_remainder, 32'd0);
        checkOutput("midResetFlags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        runOp("afterReset9div3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
